// File: rtl/ahb_lite_protocol_checker.sv
// Passive AHB-Lite protocol checker. Sits beside a subordinate, follows every
// burst beat by beat and raises sticky per-rule flags, a one-cycle violation
// pulse and a saturating violation-cycle counter. Pure RTL, no assertions.
module ahb_lite_protocol_checker #(
   parameter int ADDR_WIDTH    = 32,
   parameter int DATA_WIDTH    = 32,
   parameter int MAX_WAIT      = 16,
   parameter int ERR_CNT_WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     HRESETn,
   input  logic [1:0]               HTRANS,
   input  logic [2:0]               HBURST,
   input  logic [2:0]               HSIZE,
   input  logic                     HWRITE,
   input  logic [ADDR_WIDTH-1:0]    HADDR,
   input  logic                     HREADY,
   input  logic                     HRESP,
   input  logic                     chk_en,
   input  logic                     err_clr,
   output logic [7:0]               err_flags,
   output logic                     err_valid,
   output logic [ERR_CNT_WIDTH-1:0] err_count,
   output logic                     burst_active,
   output logic [4:0]               beats_left
);

   localparam logic [1:0] TR_IDLE   = 2'd0;
   localparam logic [1:0] TR_BUSY   = 2'd1;
   localparam logic [1:0] TR_NONSEQ = 2'd2;
   localparam logic [1:0] TR_SEQ    = 2'd3;

   localparam logic [2:0] BURST_SINGLE = 3'd0;
   localparam logic [2:0] SIZE_MAX     = 3'($clog2(DATA_WIDTH / 8));

   // 9 bits hold MAX_WAIT+1 for the largest allowed MAX_WAIT of 255
   localparam int                WAIT_W     = 9;
   localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);
   localparam logic [WAIT_W-1:0] WAIT_SAT   = WAIT_W'(MAX_WAIT + 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BURST = 2'd1,
      ST_ERR1  = 2'd2
   } state_t;

   state_t                  state;
   logic [2:0]              cap_burst;
   logic [2:0]              cap_size;
   logic                    cap_write;
   logic [ADDR_WIDTH-1:0]   cap_addr;
   logic [WAIT_W-1:0]       wait_cnt;

   // snapshot of a stalled address phase, compared one cycle later
   logic                    hold_pend;
   logic [ADDR_WIDTH-1:0]   hold_addr;
   logic [1:0]              hold_trans;
   logic [2:0]              hold_burst;
   logic [2:0]              hold_size;
   logic                    hold_write;

   logic                    accepted;
   logic                    is_fixed;
   logic [ADDR_WIDTH-1:0]   exp_addr;
   logic [7:0]              viol;

   // beats remaining after the first beat of a fixed-length burst; 0 for INCR/SINGLE
   function automatic logic [4:0] beats_load(input logic [2:0] hb);
      case (hb[2:1])
         2'd1:    return 5'd3;
         2'd2:    return 5'd7;
         2'd3:    return 5'd15;
         default: return 5'd0;
      endcase
   endfunction

   // address the next SEQ beat must carry, modulo 2^ADDR_WIDTH
   function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] prev,
                                                       input logic [2:0]            hb,
                                                       input logic [2:0]            hs);
      logic [ADDR_WIDTH-1:0] bytes;
      logic [ADDR_WIDTH-1:0] incr;
      logic [ADDR_WIDTH-1:0] mask;
      bytes = ADDR_WIDTH'(1) << hs;
      incr  = prev + bytes;
      mask  = ((ADDR_WIDTH'(beats_load(hb)) + ADDR_WIDTH'(1)) << hs) - ADDR_WIDTH'(1);
      if (hb[0] || hb == BURST_SINGLE) begin
         return incr;
      end
      return (prev & ~mask) | (incr & mask);
   endfunction

   // counter step that sticks at all-ones
   function automatic logic [ERR_CNT_WIDTH-1:0] sat_inc(input logic [ERR_CNT_WIDTH-1:0] cnt);
      return (&cnt) ? cnt : cnt + ERR_CNT_WIDTH'(1);
   endfunction

   // rule evaluation for the current cycle
   always_comb begin
      viol     = 8'h00;
      accepted = HREADY && HTRANS[1];
      is_fixed = (cap_burst[2:1] != 2'b00);
      exp_addr = next_addr(cap_addr, cap_burst, cap_size);

      if (state == ST_IDLE && HREADY && (HTRANS == TR_SEQ || HTRANS == TR_BUSY)) begin
         viol[0] = 1'b1;
      end
      if (state == ST_BURST && accepted && HTRANS == TR_SEQ) begin
         viol[1] = (HADDR != exp_addr);
         viol[2] = (HBURST != cap_burst) || (HSIZE != cap_size) || (HWRITE != cap_write);
      end
      if (state == ST_BURST && is_fixed && HREADY &&
          (HTRANS == TR_NONSEQ || HTRANS == TR_IDLE)) begin
         viol[3] = 1'b1;
      end
      if (accepted && HSIZE > SIZE_MAX) begin
         viol[4] = 1'b1;
      end
      if (!HREADY && wait_cnt == WAIT_LIMIT) begin
         viol[5] = 1'b1;
      end
      // the manager may cancel a stalled transfer during the second ERROR cycle
      if (hold_pend && (HADDR != hold_addr || HBURST != hold_burst ||
                        HSIZE != hold_size || HWRITE != hold_write ||
                        (HTRANS != hold_trans && state != ST_ERR1))) begin
         viol[6] = 1'b1;
      end
      if (state == ST_ERR1) begin
         viol[7] = !(HRESP && HREADY);
      end else begin
         viol[7] = HRESP && HREADY;
      end
      if (!chk_en) begin
         viol = 8'h00;
      end
   end

   // burst-tracking FSM, wait counter and violation reporting
   always_ff @(posedge clk) begin
      if (!HRESETn) begin
         state        <= ST_IDLE;
         cap_burst    <= 3'd0;
         cap_size     <= 3'd0;
         cap_write    <= 1'b0;
         cap_addr     <= '0;
         beats_left   <= 5'd0;
         burst_active <= 1'b0;
         wait_cnt     <= '0;
         hold_pend    <= 1'b0;
         err_flags    <= 8'h00;
         err_valid    <= 1'b0;
         err_count    <= '0;
      end else begin
         if (HREADY) begin
            wait_cnt <= '0;
         end else if (wait_cnt != WAIT_SAT) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
         end
         hold_pend <= !HREADY && HTRANS[1];

         err_flags <= (err_clr ? 8'h00 : err_flags) | viol;
         err_valid <= |viol;
         if (|viol) begin
            err_count <= sat_inc(err_count);
         end

         if (HRESP && !HREADY) begin
            state        <= ST_ERR1;
            beats_left   <= 5'd0;
            burst_active <= 1'b0;
         end else if (accepted && HTRANS == TR_NONSEQ) begin
            cap_burst <= HBURST;
            cap_size  <= HSIZE;
            cap_write <= HWRITE;
            cap_addr  <= HADDR;
            if (HBURST != BURST_SINGLE) begin
               state        <= ST_BURST;
               beats_left   <= beats_load(HBURST);
               burst_active <= 1'b1;
            end else begin
               state        <= ST_IDLE;
               beats_left   <= 5'd0;
               burst_active <= 1'b0;
            end
         end else if (state == ST_ERR1) begin
            state <= ST_IDLE;
         end else if (state == ST_BURST) begin
            if (accepted) begin
               cap_addr <= HADDR;
               if (is_fixed) begin
                  beats_left <= beats_left - 5'd1;
                  if (beats_left == 5'd1) begin
                     state        <= ST_IDLE;
                     burst_active <= 1'b0;
                  end
               end
            end else if (HREADY && HTRANS == TR_IDLE) begin
               state        <= ST_IDLE;
               beats_left   <= 5'd0;
               burst_active <= 1'b0;
            end
         end
      end
   end

   // stalled address-phase snapshot; only consulted when hold_pend is set
   always_ff @(posedge clk) begin
      hold_addr  <= HADDR;
      hold_trans <= HTRANS;
      hold_burst <= HBURST;
      hold_size  <= HSIZE;
      hold_write <= HWRITE;
   end

endmodule

// File: tb/tb_ahb_lite_protocol_checker.sv
// Bench for ahb_lite_protocol_checker: directed scenarios followed by random
// AHB-Lite traffic, every cycle compared against a transaction-level model.
module tb_ahb_lite_protocol_checker;

   localparam int MW = 4;
   localparam int CW = 4;

   localparam logic [1:0] T_IDLE   = 2'd0;
   localparam logic [1:0] T_BUSY   = 2'd1;
   localparam logic [1:0] T_NONSEQ = 2'd2;
   localparam logic [1:0] T_SEQ    = 2'd3;

   logic          clk = 1'b0;
   logic          hresetn;
   logic [1:0]    htrans;
   logic [2:0]    hburst;
   logic [2:0]    hsize;
   logic          hwrite;
   logic [31:0]   haddr;
   logic          hready;
   logic          hresp;
   logic          chk_en;
   logic          err_clr;
   logic [7:0]    err_flags;
   logic          err_valid;
   logic [CW-1:0] err_count;
   logic          burst_active;
   logic [4:0]    beats_left;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   ahb_lite_protocol_checker #(
      .ADDR_WIDTH    (32),
      .DATA_WIDTH    (32),
      .MAX_WAIT      (MW),
      .ERR_CNT_WIDTH (CW)
   ) dut (
      .clk          (clk),
      .HRESETn      (hresetn),
      .HTRANS       (htrans),
      .HBURST       (hburst),
      .HSIZE        (hsize),
      .HWRITE       (hwrite),
      .HADDR        (haddr),
      .HREADY       (hready),
      .HRESP        (hresp),
      .chk_en       (chk_en),
      .err_clr      (err_clr),
      .err_flags    (err_flags),
      .err_valid    (err_valid),
      .err_count    (err_count),
      .burst_active (burst_active),
      .beats_left   (beats_left)
   );

   always #5 clk = ~clk;

   // reference model: open burst described by its length and beats done so far
   bit          m_open;
   bit          m_err;
   int          m_len;
   int          m_done;
   logic [2:0]  m_burst;
   logic [2:0]  m_size;
   logic        m_write;
   logic [31:0] m_last;
   int          m_low_run;
   bit          m_pend;
   logic [1:0]  p_trans;
   logic [2:0]  p_burst;
   logic [2:0]  p_size;
   logic        p_write;
   logic [31:0] p_addr;
   logic [7:0]  x_flags;
   bit          x_valid;
   int          x_count;
   bit          x_active;
   int          x_beats;

   function automatic int burst_len(input logic [2:0] hb);
      case (hb)
         3'd2, 3'd3: return 4;
         3'd4, 3'd5: return 8;
         3'd6, 3'd7: return 16;
         default:    return 0;
      endcase
   endfunction

   // next legal address: wrap bursts stay inside their aligned window
   function automatic logic [31:0] ref_next(input logic [31:0] prev, input logic [2:0] hb,
                                            input logic [2:0] hs);
      longint unsigned p, bytes, span, base;
      p     = 64'(prev);
      bytes = 64'd1 << hs;
      if (hb == 3'd2 || hb == 3'd4 || hb == 3'd6) begin
         span = bytes * 64'(burst_len(hb));
         base = p - (p % span);
         return 32'(base + ((p - base + bytes) % span));
      end
      return 32'(p + bytes);
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic model_update();
      logic [7:0] v;
      bit         acc;
      bit         fixed;
      v = 8'h00;
      if (!hresetn) begin
         m_open = 0; m_err = 0; m_len = 0; m_done = 0; m_last = '0;
         m_burst = '0; m_size = '0; m_write = 1'b0; m_low_run = 0; m_pend = 0;
         x_flags = 8'h00; x_valid = 0; x_count = 0; x_active = 0; x_beats = 0;
         return;
      end
      acc       = hready && htrans[1];
      fixed     = m_open && (m_len != 0);
      m_low_run = hready ? 0 : m_low_run + 1;

      if (!m_open && !m_err && hready && (htrans == T_SEQ || htrans == T_BUSY)) v[0] = 1'b1;
      if (m_open && acc && htrans == T_SEQ) begin
         if (haddr != ref_next(m_last, m_burst, m_size)) v[1] = 1'b1;
         if (hburst != m_burst || hsize != m_size || hwrite != m_write) v[2] = 1'b1;
      end
      if (fixed && hready && (htrans == T_NONSEQ || htrans == T_IDLE)) v[3] = 1'b1;
      if (acc && hsize > 3'd2) v[4] = 1'b1;
      if (m_low_run == MW + 1) v[5] = 1'b1;
      if (m_pend && (haddr != p_addr || hburst != p_burst || hsize != p_size ||
                     hwrite != p_write || (htrans != p_trans && !m_err))) v[6] = 1'b1;
      v[7] = m_err ? !(hresp && hready) : (hresp && hready);
      if (!chk_en) v = 8'h00;

      x_flags = (err_clr ? 8'h00 : x_flags) | v;
      x_valid = |v;
      if (|v && x_count < (1 << CW) - 1) x_count++;

      if (hresp && !hready) begin
         m_err  = 1;
         m_open = 0;
      end else if (acc && htrans == T_NONSEQ) begin
         m_err   = 0;
         m_open  = (hburst != 3'd0);
         m_len   = burst_len(hburst);
         m_done  = 1;
         m_burst = hburst; m_size = hsize; m_write = hwrite; m_last = haddr;
      end else if (m_err) begin
         m_err = 0;
      end else if (m_open) begin
         if (acc) begin
            m_last = haddr;
            m_done++;
            if (m_len != 0 && m_done == m_len) m_open = 0;
         end else if (hready && htrans == T_IDLE) begin
            m_open = 0;
         end
      end

      m_pend  = !hready && htrans[1];
      p_trans = htrans; p_burst = hburst; p_size = hsize; p_write = hwrite; p_addr = haddr;
      x_active = m_open;
      x_beats  = (m_open && m_len != 0) ? m_len - m_done : 0;
   endtask

   task automatic step();
      model_update();
      @(posedge clk);
      #1;
      cyc++;
      check_eq("err_flags",    32'(err_flags),    32'(x_flags));
      check_eq("err_valid",    32'(err_valid),    32'(x_valid));
      check_eq("err_count",    32'(err_count),    32'(x_count));
      check_eq("burst_active", 32'(burst_active), 32'(x_active));
      check_eq("beats_left",   32'(beats_left),   32'(x_beats));
   endtask

   task automatic drive(input logic [1:0] tr, input logic [2:0] hb, input logic [2:0] hs,
                        input logic [31:0] a, input logic rdy, input logic rsp);
      htrans = tr; hburst = hb; hsize = hs; haddr = a; hready = rdy; hresp = rsp;
      step();
   endtask

   task automatic drive_r(input logic [1:0] tr, input logic [2:0] hb, input logic [2:0] hs,
                          input logic [31:0] a, input logic rdy, input logic rsp);
      err_clr = ($urandom_range(0, 15) == 0);
      drive(tr, hb, hs, a, rdy, rsp);
   endtask

   task automatic do_reset();
      hresetn = 1'b0;
      drive(T_IDLE, 3'd0, 3'd0, 32'd0, 1'b1, 1'b0);
      hresetn = 1'b1;
   endtask

   initial begin
      hresetn = 1'b0; htrans = T_IDLE; hburst = 3'd0; hsize = 3'd0; hwrite = 1'b0;
      haddr = 32'd0; hready = 1'b1; hresp = 1'b0; chk_en = 1'b1; err_clr = 1'b0;
      step();
      step();
      check_eq("rst_flags",  32'(err_flags),    32'h0);
      check_eq("rst_count",  32'(err_count),    32'h0);
      check_eq("rst_active", 32'(burst_active), 32'h0);
      hresetn = 1'b1;

      // legal INCR4
      drive(T_NONSEQ, 3'd3, 3'd2, 32'h100, 1'b1, 1'b0);
      check_eq("incr4_left0", 32'(beats_left), 32'd3);
      drive(T_SEQ, 3'd3, 3'd2, 32'h104, 1'b1, 1'b0);
      check_eq("incr4_left1", 32'(beats_left), 32'd2);
      drive(T_SEQ, 3'd3, 3'd2, 32'h108, 1'b1, 1'b0);
      check_eq("incr4_left2", 32'(beats_left), 32'd1);
      drive(T_SEQ, 3'd3, 3'd2, 32'h10C, 1'b1, 1'b0);
      check_eq("incr4_left3", 32'(beats_left), 32'd0);
      check_eq("incr4_done",  32'(burst_active), 32'd0);
      drive(T_IDLE, 3'd0, 3'd0, 32'd0, 1'b1, 1'b0);
      check_eq("incr4_flags", 32'(err_flags), 32'h0);
      check_eq("incr4_count", 32'(err_count), 32'h0);

      // legal WRAP8 from 0x3C
      drive(T_NONSEQ, 3'd4, 3'd2, 32'h3C, 1'b1, 1'b0);
      for (int i = 0; i < 7; i++) drive(T_SEQ, 3'd4, 3'd2, 32'h20 + 32'(4 * i), 1'b1, 1'b0);
      check_eq("wrap8_flags", 32'(err_flags), 32'h0);
      check_eq("wrap8_done",  32'(burst_active), 32'd0);

      // WRAP8 with a bad second beat
      drive(T_NONSEQ, 3'd4, 3'd2, 32'h3C, 1'b1, 1'b0);
      drive(T_SEQ, 3'd4, 3'd2, 32'h40, 1'b1, 1'b0);
      check_eq("wrap8_bad_flags", 32'(err_flags), 32'h02);
      check_eq("wrap8_bad_valid", 32'(err_valid), 32'd1);
      check_eq("wrap8_bad_count", 32'(err_count), 32'd1);
      drive(T_BUSY, 3'd4, 3'd2, 32'h44, 1'b1, 1'b0);
      check_eq("wrap8_pulse_end", 32'(err_valid), 32'd0);
      do_reset();

      // INCR8 cut short by NONSEQ
      drive(T_NONSEQ, 3'd5, 3'd2, 32'h200, 1'b1, 1'b0);
      for (int i = 1; i < 5; i++) drive(T_SEQ, 3'd5, 3'd2, 32'h200 + 32'(4 * i), 1'b1, 1'b0);
      drive(T_NONSEQ, 3'd3, 3'd2, 32'h300, 1'b1, 1'b0);
      check_eq("short_flags",  32'(err_flags),    32'h08);
      check_eq("short_active", 32'(burst_active), 32'd1);
      do_reset();

      // wait timeout with MAX_WAIT=4
      for (int i = 1; i <= 6; i++) begin
         drive(T_IDLE, 3'd0, 3'd0, 32'd0, 1'b0, 1'b0);
         if (i == 4) check_eq("wait4_flags", 32'(err_flags), 32'h0);
         if (i == 5) check_eq("wait5_valid", 32'(err_valid), 32'd1);
         if (i == 6) check_eq("wait6_valid", 32'(err_valid), 32'd0);
      end
      check_eq("wait_flags", 32'(err_flags), 32'h20);
      check_eq("wait_count", 32'(err_count), 32'd1);
      err_clr = 1'b1;
      drive(T_IDLE, 3'd0, 3'd0, 32'd0, 1'b1, 1'b0);
      err_clr = 1'b0;
      check_eq("clr_flags", 32'(err_flags), 32'h0);
      check_eq("clr_count", 32'(err_count), 32'd1);
      do_reset();

      // two-cycle ERROR mid-WRAP4, then a lone ERROR
      drive(T_NONSEQ, 3'd2, 3'd2, 32'h10, 1'b1, 1'b0);
      drive(T_SEQ, 3'd2, 3'd2, 32'h14, 1'b1, 1'b0);
      drive(T_SEQ, 3'd2, 3'd2, 32'h18, 1'b0, 1'b1);
      drive(T_IDLE, 3'd2, 3'd2, 32'h18, 1'b1, 1'b1);
      check_eq("err2_flags",  32'(err_flags),    32'h0);
      check_eq("err2_active", 32'(burst_active), 32'd0);
      drive(T_IDLE, 3'd0, 3'd0, 32'd0, 1'b1, 1'b1);
      check_eq("err1_flags", 32'(err_flags), 32'h80);
      do_reset();

      // oversized transfer
      drive(T_NONSEQ, 3'd0, 3'd3, 32'd0, 1'b1, 1'b0);
      check_eq("size_flags", 32'(err_flags), 32'h10);
      do_reset();

      // reset in the middle of INCR16
      drive(T_NONSEQ, 3'd7, 3'd2, 32'h400, 1'b1, 1'b0);
      drive(T_SEQ, 3'd7, 3'd2, 32'h404, 1'b1, 1'b0);
      drive(T_SEQ, 3'd7, 3'd2, 32'h408, 1'b1, 1'b0);
      do_reset();
      check_eq("midrst_active", 32'(burst_active), 32'd0);
      check_eq("midrst_left",   32'(beats_left),   32'd0);
      check_eq("midrst_flags",  32'(err_flags),    32'h0);
      drive(T_SEQ, 3'd7, 3'd2, 32'h40C, 1'b1, 1'b0);
      check_eq("midrst_seq", 32'(err_flags), 32'h01);
      do_reset();

      // random traffic: mostly legal bursts with occasional faults
      for (int b = 0; b < 250; b++) begin
         logic [2:0]  hb;
         logic [2:0]  hs;
         logic [2:0]  ths;
         logic [1:0]  tr;
         logic [31:0] a;
         int          nb;
         int          w;
         chk_en = ($urandom_range(0, 9) != 0);
         hwrite = 1'($urandom_range(0, 1));
         hb     = 3'($urandom_range(0, 7));
         hs     = ($urandom_range(0, 15) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
         a      = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFC0 : $urandom;
         a      = a & ~((32'd1 << hs) - 32'd1);
         nb     = burst_len(hb);
         if (hb == 3'd1) nb = $urandom_range(1, 6);
         if (hb == 3'd0) nb = 1;
         if ($urandom_range(0, 9) == 0) nb = $urandom_range(1, nb);
         for (int i = 0; i < nb; i++) begin
            if (i > 0) a = ref_next(a, hb, hs);
            tr  = (i == 0) ? T_NONSEQ : T_SEQ;
            ths = hs;
            if (i > 0 && $urandom_range(0, 19) == 0) a = a ^ 32'h4;
            if (i > 0 && $urandom_range(0, 29) == 0) ths = hs ^ 3'd1;
            if (i > 0 && $urandom_range(0, 7) == 0) drive_r(T_BUSY, hb, ths, a, 1'b1, 1'b0);
            w = ($urandom_range(0, 14) == 0) ? 6 : $urandom_range(0, 2);
            for (int k = 0; k < w; k++)
               drive_r(tr, hb, ths, ($urandom_range(0, 29) == 0) ? a + 32'd4 : a, 1'b0, 1'b0);
            if ($urandom_range(0, 24) == 0) begin
               drive_r(tr, hb, ths, a, 1'b0, 1'b1);
               drive_r(T_IDLE, hb, ths, a, 1'b1, 1'($urandom_range(0, 9) != 0));
               break;
            end
            drive_r(tr, hb, ths, a, 1'b1, 1'($urandom_range(0, 49) == 0));
         end
         w = $urandom_range(0, 2);
         for (int k = 0; k < w; k++) drive_r(T_IDLE, 3'd0, 3'd0, 32'd0, 1'b1, 1'b0);
         if ($urandom_range(0, 39) == 0) do_reset();
      end
      err_clr = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
